// File: rtl/line_buffer_window.sv
// ---------------------------------------------------------------------------
// line_buffer_window
// Streaming KxK sliding-window generator for a square feature map delivered
// in raster order, one pixel per accepted strobe. K-1 line buffers keep the
// previous rows, so each accepted pixel completes one vertical K-pixel
// column. That column is shifted into a KxK window register. A window is
// flagged valid only when it lies fully inside the map, so windows that
// would straddle a row boundary are never reported.
// ---------------------------------------------------------------------------
module line_buffer_window #(
    parameter int I_BW    = 8,
    parameter int IF_SIZE = 28,
    parameter int K       = 3
) (
    input  logic                  clk,
    input  logic                  global_rst_n,
    input  logic                  i_ce,
    input  logic                  i_rst,
    input  logic                  i_load_data,
    input  logic [I_BW-1:0]       i_data,
    output logic [K*K*I_BW-1:0]   o_window,
    output logic                  o_valid,
    output logic                  o_done
);

    localparam int              CW   = (IF_SIZE > 1) ? $clog2(IF_SIZE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(IF_SIZE - 1);
    localparam logic [CW-1:0]   KM1  = CW'(K - 1);

    // Position of the pixel being accepted on the current edge.
    logic [CW-1:0]   r_row;
    logic [CW-1:0]   r_col;

    // Line buffers: index 0 holds the oldest row, index K-2 the newest one.
    logic [I_BW-1:0] r_lb  [K-1][IF_SIZE];

    // Window register: [row][col], row 0 oldest, col 0 leftmost.
    logic [I_BW-1:0] r_win [K][K];

    logic            r_valid;
    logic            r_done;

    // The K-pixel vertical column completed by the current input pixel.
    logic [I_BW-1:0] w_col [K];
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;

    assign w_accept   = i_ce & i_load_data & ~i_rst;
    assign w_col_last = (r_col == LAST);
    assign w_row_last = (r_row == LAST);

    // Gather the stored pixels above the current position plus the new pixel.
    always_comb begin
        // NOTE: every element gets a value on every pass, so no latch is inferred.
        for (int j = 0; j < K; j++) begin
            w_col[j] = '0;
        end
        for (int j = 0; j < K - 1; j++) begin
            w_col[j] = r_lb[j][r_col];
        end
        w_col[K-1] = i_data;
    end

    // Raster position counters; a frame clear wins over an accept.
    always_ff @(posedge clk or negedge global_rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
        if (!global_rst_n) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + CW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Line buffers: each column slot moves up one row and takes in the new pixel.
    always_ff @(posedge clk or negedge global_rst_n) begin
        // NOTE: this storage sits in flops and must come up as zero, so every entry is reset here.
        if (!global_rst_n) begin
            for (int j = 0; j < K - 1; j++) begin
                for (int x = 0; x < IF_SIZE; x++) begin
                    r_lb[j][x] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int j = 0; j < K - 1; j++) begin
                r_lb[j][r_col] <= w_col[j+1];
            end
        end
    end

    // Window register: shift one column left and load the new column on the right.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][K-1] <= w_col[r];
            end
        end
    end

    // Valid/done flags: a window is complete once the K-1 fill rows and columns have passed.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_rst) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= w_accept && (r_row >= KM1) && (r_col >= KM1);
            r_done  <= w_accept && w_row_last && w_col_last;
        end
    end

    // Flatten the window so that element (r,c) sits at slot r*K+c.
    always_comb begin
        o_window = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                o_window[(r*K+c)*I_BW +: I_BW] = r_win[r][c];
            end
        end
    end

    assign o_valid = r_valid;
    assign o_done  = r_done;

endmodule

// File: tb/tb_line_buffer_window.sv
// ---------------------------------------------------------------------------
// tb_line_buffer_window
// Self-checking bench for line_buffer_window at default parameters. A
// behavioural model keeps the whole current frame as a 2-D image and derives
// each expected window directly from image coordinates. One compare process
// checks the outputs against it on every cycle. Literal windows and
// window counts pin the model itself.
// ---------------------------------------------------------------------------
module tb_line_buffer_window;

    localparam int I_BW = 8;
    localparam int N    = 28;
    localparam int K    = 3;
    localparam int WW   = K * K * I_BW;
    localparam int NWIN = (N - K + 1) * (N - K + 1);

    logic            clk          = 1'b0;
    logic            global_rst_n = 1'b0;
    logic            i_ce         = 1'b0;
    logic            i_rst        = 1'b0;
    logic            i_load_data  = 1'b0;
    logic [I_BW-1:0] i_data       = '0;
    logic [WW-1:0]   o_window;
    logic            o_valid;
    logic            o_done;

    line_buffer_window #(.I_BW(I_BW), .IF_SIZE(N), .K(K)) dut (
        .clk          (clk),
        .global_rst_n (global_rst_n),
        .i_ce         (i_ce),
        .i_rst        (i_rst),
        .i_load_data  (i_load_data),
        .i_data       (i_data),
        .o_window     (o_window),
        .o_valid      (o_valid),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [I_BW-1:0] img [N][N];
    int              m_row     = 0;
    int              m_col     = 0;
    logic            exp_valid = 1'b0;
    logic            exp_done  = 1'b0;
    logic            exp_first = 1'b0;
    logic            hold_ok   = 1'b1;
    logic [WW-1:0]   exp_win   = '0;

    // Window ending at (row,col): element (r,c) is image pixel (row-K+1+r, col-K+1+c).
    function automatic logic [WW-1:0] calc_win(input int row, input int col, input logic [I_BW-1:0] pix);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                int pr;
                int pc;
                pr = row - K + 1 + r;
                pc = col - K + 1 + c;
                w[(r*K+c)*I_BW +: I_BW] = (pr == row && pc == col) ? pix : img[pr][pc];
            end
        end
        return w;
    endfunction

    always @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            m_row     <= 0;
            m_col     <= 0;
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
            exp_first <= 1'b0;
            exp_win   <= '0;
            hold_ok   <= 1'b1;
        end else if (i_rst) begin
            m_row     <= 0;
            m_col     <= 0;
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
            exp_first <= 1'b0;
            hold_ok   <= 1'b0;
        end else if (i_ce && i_load_data) begin
            img[m_row][m_col] <= i_data;
            exp_valid <= (m_row >= K - 1) && (m_col >= K - 1);
            exp_done  <= (m_row == N - 1) && (m_col == N - 1);
            exp_first <= (m_row == K - 1) && (m_col == K - 1);
            hold_ok   <= (m_row >= K - 1) && (m_col >= K - 1);
            if ((m_row >= K - 1) && (m_col >= K - 1))
                exp_win <= calc_win(m_row, m_col, i_data);
            m_col <= (m_col == N - 1) ? 0 : m_col + 1;
            if (m_col == N - 1)
                m_row <= (m_row == N - 1) ? 0 : m_row + 1;
        end else begin
            exp_valid <= 1'b0;
            exp_done  <= 1'b0;
            exp_first <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    int            tot_valid = 0;
    int            tot_done  = 0;
    logic [WW-1:0] cap_first = '0;
    logic [WW-1:0] cap_last  = '0;

    always @(negedge clk) begin
        check("valid", WW'(o_valid), WW'(exp_valid));
        check("done", WW'(o_done), WW'(exp_done));
        if (exp_valid)
            check("window", o_window, exp_win);
        else if (hold_ok)
            check("window_hold", o_window, exp_win);
        if (o_valid) tot_valid++;
        if (o_done)  tot_done++;
        if (o_valid && exp_first) cap_first = o_window;
        if (o_done) cap_last = o_window;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ce, input bit ld, input bit rst, input logic [I_BW-1:0] d);
        @(negedge clk);
        #1;
        i_ce        = ce;
        i_load_data = ld;
        i_rst       = rst;
        i_data      = d;
    endtask

    // Stream pixels from (0,0) up to, but not including, (stop_r,stop_c).
    task automatic stream_frame(input bit ordered, input bit gaps, input int stall_r, input int stall_c,
                                input int stop_r, input int stop_c);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (r == stall_r && c == stall_c)
                    repeat (5) drive(1'b0, 1'b1, 1'b0, 8'hAA);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    bit g;
                    g = 1'($urandom_range(0, 1));
                    drive(g, ~g, 1'b0, 8'($urandom));
                end
                drive(1'b1, 1'b1, 1'b0, ordered ? 8'((r * N + c) % 256) : 8'($urandom));
            end
        end
    endtask

    function automatic logic [WW-1:0] pack(input int v[K*K]);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < K * K; i++) w[i*I_BW +: I_BW] = 8'(v[i]);
        return w;
    endfunction

    int            first_lit[K*K] = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
    int            last_lit[K*K]  = '{213, 214, 215, 241, 242, 243, 13, 14, 15};
    int            v0;
    int            d0;

    initial begin
        repeat (3) @(negedge clk);
        #2 global_rst_n = 1'b1;
        #1;
        check("rst_valid", WW'(o_valid), '0);
        check("rst_done", WW'(o_done), '0);
        check("rst_window", o_window, '0);

        // Gating: load disabled, then a clear that must drop its pixel.
        v0 = tot_valid;
        repeat (10) drive(1'b1, 1'b0, 1'b0, 8'h5A);
        drive(1'b1, 1'b1, 1'b1, 8'h77);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("gate_valids", WW'(tot_valid - v0), '0);

        // Continuous ordered frame with literal first/last windows.
        v0 = tot_valid; d0 = tot_done;
        stream_frame(1'b1, 1'b0, -1, -1, N, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("frame_valids", WW'(tot_valid - v0), WW'(NWIN));
        check("frame_dones", WW'(tot_done - d0), WW'(1));
        check("first_window_lit", cap_first, pack(first_lit));
        check("last_window_lit", cap_last, pack(last_lit));

        // Five-cycle stall at (10,15).
        v0 = tot_valid; d0 = tot_done;
        stream_frame(1'b1, 1'b0, 10, 15, N, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("stall_valids", WW'(tot_valid - v0), WW'(NWIN));
        check("stall_dones", WW'(tot_done - d0), WW'(1));
        check("stall_last_lit", cap_last, pack(last_lit));

        // Synchronous clear at (12,7), then a fresh frame.
        stream_frame(1'b1, 1'b0, -1, -1, 12, 7);
        drive(1'b1, 1'b1, 1'b1, 8'hEE);
        v0 = tot_valid; d0 = tot_done;
        stream_frame(1'b1, 1'b0, -1, -1, N, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("clear_valids", WW'(tot_valid - v0), WW'(NWIN));
        check("clear_dones", WW'(tot_done - d0), WW'(1));
        check("clear_first_lit", cap_first, pack(first_lit));

        // Two back-to-back random frames with random gaps.
        v0 = tot_valid; d0 = tot_done;
        stream_frame(1'b0, 1'b1, -1, -1, N, 0);
        stream_frame(1'b0, 1'b1, -1, -1, N, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("b2b_valids", WW'(tot_valid - v0), WW'(2 * NWIN));
        check("b2b_dones", WW'(tot_done - d0), WW'(2));

        // Asynchronous reset in the middle of a frame.
        stream_frame(1'b0, 1'b1, -1, -1, 15, 3);
        @(negedge clk);
        #2 global_rst_n = 1'b0;
        #1;
        check("arst_valid", WW'(o_valid), '0);
        check("arst_done", WW'(o_done), '0);
        check("arst_window", o_window, '0);
        i_ce = 1'b0; i_load_data = 1'b0; i_rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 global_rst_n = 1'b1;
        v0 = tot_valid; d0 = tot_done;
        stream_frame(1'b1, 1'b0, -1, -1, N, 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("arst_frame_valids", WW'(tot_valid - v0), WW'(NWIN));
        check("arst_frame_dones", WW'(tot_done - d0), WW'(1));
        check("arst_first_lit", cap_first, pack(first_lit));
        check("arst_last_lit", cap_last, pack(last_lit));

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
